// File: rtl/simple_st0_error_buffer.sv
// simple_st0_error_buffer: four-bank stage-0 error capture with per-bank burst replay
module simple_st0_error_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  error_valid,
    input  logic [DATA_WIDTH-1:0] error_value,
    input  logic [1:0]            error_phase,
    input  logic [31:0]           error_sub_address,
    input  logic [2:0]            load_length,
    input  logic                  error_update_first,
    input  logic [1:0]            error_phase_read,
    input  logic                  rd_ready,
    input  logic                  clear_errors,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_first,
    output logic                  rd_last,
    output logic                  busy,
    output logic [3:0]            phase_full,
    output logic [2:0]            err_status
);
    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] mem [4][2**ADDR_WIDTH];
    logic [1:0] rd_phase;
    logic [ADDR_WIDTH-1:0] rd_ptr, sub;
    logic [2:0] rd_len, err_event;
    logic [3:0] set_mask, clr_mask;
    logic wr_ok, wr_last, start_ok, accept, done;
    assign sub = error_sub_address[ADDR_WIDTH-1:0];
    assign wr_ok = error_valid && !phase_full[error_phase];
    assign wr_last = 32'(sub) == 32'(load_length);
    always_comb begin
        rd_valid = state == READ;
        busy = rd_valid;
        rd_data = mem[rd_phase][rd_ptr];
        rd_first = rd_valid && rd_ptr == '0;
        rd_last = rd_valid && 32'(rd_ptr) == 32'(rd_len);
        accept = rd_valid && rd_ready;
        done = accept && rd_last;
        start_ok = !rd_valid && error_update_first && phase_full[error_phase_read];
        err_event = {error_update_first && rd_valid,
                     error_update_first && !rd_valid && !phase_full[error_phase_read],
                     error_valid && phase_full[error_phase]};
        set_mask = (wr_ok && wr_last) ? 4'b1 << error_phase : 4'b0;
        clr_mask = done ? 4'b1 << rd_phase : 4'b0;
        state_nx = start_ok ? READ : done ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end
    // A set and a clear never target the same bank: writes need an empty bank, release needs a full one
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_phase <= '0;
            rd_ptr <= '0;
            rd_len <= '0;
            phase_full <= '0;
            err_status <= '0;
        end else begin
            phase_full <= (phase_full & ~clr_mask) | set_mask;
            err_status <= clear_errors ? err_event : err_status | err_event;
            if (start_ok) begin
                rd_phase <= error_phase_read;
                rd_len <= load_length;
                rd_ptr <= '0;
            end else if (accept && !rd_last) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (wr_ok) mem[error_phase][sub] <= error_value;
    end
endmodule

// File: tb/tb_simple_st0_error_buffer.sv
// tb_simple_st0_error_buffer: randomized and directed checks against a queue-based bank model
module tb_simple_st0_error_buffer;
    logic clk = 0, reset = 0;
    logic error_valid = 0, error_update_first = 0, rd_ready = 0, clear_errors = 0;
    logic [31:0] error_value = 0, error_sub_address = 0;
    logic [1:0] error_phase = 0, error_phase_read = 0;
    logic [2:0] load_length = 0;
    logic [31:0] rd_data;
    logic rd_valid, rd_first, rd_last, busy;
    logic [3:0] phase_full;
    logic [2:0] err_status;

    simple_st0_error_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .error_valid(error_valid), .error_value(error_value),
        .error_phase(error_phase), .error_sub_address(error_sub_address),
        .load_length(load_length), .error_update_first(error_update_first),
        .error_phase_read(error_phase_read), .rd_ready(rd_ready), .clear_errors(clear_errors),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_first(rd_first), .rd_last(rd_last),
        .busy(busy), .phase_full(phase_full), .err_status(err_status)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [31:0] mm [4][8];
    logic [3:0] mfull = 0;
    logic [2:0] merr = 0;
    bit mbusy = 0, mfirst = 0;
    int mbank = 0;
    logic [31:0] q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("rd_valid", rd_valid, mbusy);
        chk("busy", busy, mbusy);
        chk("phase_full", phase_full, mfull);
        chk("err_status", err_status, merr);
        if (mbusy) begin
            chk("rd_data", rd_data, q[0]);
            chk("rd_first", rd_first, mfirst);
            chk("rd_last", rd_last, q.size() == 1);
        end
    endtask

    // The replayed burst is a snapshot of the bank: writes into a full bank are always dropped
    task automatic model_step();
        logic [3:0] of;
        logic [2:0] ev;
        logic [2:0] s;
        of = mfull;
        ev = 0;
        s = error_sub_address[2:0];
        if (!reset) begin
            mfull = 0; merr = 0; mbusy = 0; q.delete();
            return;
        end
        if (error_valid) begin
            if (of[error_phase]) ev[0] = 1;
            else begin
                mm[error_phase][s] = error_value;
                if (s == load_length) mfull[error_phase] = 1;
            end
        end
        if (mbusy) begin
            if (error_update_first) ev[2] = 1;
            if (rd_ready) begin
                void'(q.pop_front());
                mfirst = 0;
                if (q.size() == 0) begin
                    mbusy = 0;
                    mfull[mbank] = 0;
                end
            end
        end else if (error_update_first) begin
            if (of[error_phase_read]) begin
                mbusy = 1; mfirst = 1; mbank = int'(error_phase_read);
                for (int i = 0; i <= int'(load_length); i++) q.push_back(mm[error_phase_read][i]);
            end else ev[1] = 1;
        end
        merr = clear_errors ? ev : (merr | ev);
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] ph, input logic [31:0] s, input logic [31:0] v);
        error_valid = 1; error_phase = ph; error_sub_address = s; error_value = v;
        cycle();
        error_valid = 0;
    endtask

    task automatic start(input logic [1:0] ph);
        error_update_first = 1; error_phase_read = ph;
        cycle();
        error_update_first = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1;
        while (mbusy && n < 40) begin
            cycle();
            n++;
        end
        chk("drain_timeout", mbusy, 0);
    endtask

    task automatic clr();
        clear_errors = 1;
        cycle();
        clear_errors = 0;
    endtask

    task automatic fill(input logic [1:0] ph, input logic [31:0] base);
        for (int i = 0; i < 4; i++) wr(ph, 32'(i), base + 32'(i));
    endtask

    initial begin
        logic [31:0] got[4];
        int n;
        reset = 0;
        cycle();
        cycle();
        reset = 1;
        chk("reset_pf", phase_full, 4'b0000);
        chk("reset_err", err_status, 3'b000);
        chk("reset_valid", rd_valid, 0);
        load_length = 7;
        for (int b = 0; b < 4; b++)
            for (int s = 0; s < 8; s++) wr(2'(b), 32'(s), $urandom);
        chk("init_full", phase_full, 4'b1111);
        for (int b = 0; b < 4; b++) begin
            start(2'(b));
            drain();
        end
        chk("init_empty", phase_full, 4'b0000);

        load_length = 3;
        fill(2'd1, 32'h10);
        chk("fill_pf", phase_full, 4'b0010);
        rd_ready = 1;
        start(2'd1);
        for (int i = 0; i < 4; i++) begin
            chk("replay_data", rd_data, 32'h10 + 32'(i));
            chk("replay_first", rd_first, i == 0);
            chk("replay_last", rd_last, i == 3);
            cycle();
        end
        chk("replay_busy", busy, 0);
        chk("replay_pf", phase_full, 4'b0000);

        fill(2'd1, 32'h10);
        rd_ready = 0;
        start(2'd1);
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            rd_ready = (k % 3 == 0);
            if (rd_valid && rd_ready) got[n++] = rd_data;
            cycle();
        end
        chk("bp_count", n, 4);
        for (int i = 0; i < 4; i++) chk("bp_data", got[i], 32'h10 + 32'(i));
        chk("bp_busy", busy, 0);

        fill(2'd2, 32'h20);
        wr(2'd2, 0, 32'hDEAD);
        chk("ovf_err", err_status, 3'b001);
        rd_ready = 1;
        start(2'd2);
        chk("ovf_data", rd_data, 32'h20);
        drain();
        clr();
        chk("clear_err", err_status, 3'b000);

        start(2'd0);
        chk("udf_err", err_status, 3'b010);
        chk("udf_valid", rd_valid, 0);
        clr();

        fill(2'd3, 32'h30);
        rd_ready = 0;
        start(2'd3);
        start(2'd3);
        chk("coll_err", err_status, 3'b100);
        chk("coll_data", rd_data, 32'h30);
        drain();
        chk("coll_pf", phase_full, 4'b0000);
        clr();

        for (int i = 0; i < 3; i++) wr(2'd3, 32'(i), 32'h40 + 32'(i));
        error_valid = 1; error_phase = 3; error_sub_address = 3; error_value = 32'h43;
        error_update_first = 1; error_phase_read = 3;
        cycle();
        error_valid = 0; error_update_first = 0;
        chk("same_err", err_status, 3'b010);
        chk("same_busy", busy, 0);
        chk("same_pf", phase_full, 4'b1000);
        start(2'd3);
        chk("late_busy", busy, 1);
        chk("late_data", rd_data, 32'h40);
        drain();
        clr();

        fill(2'd1, 32'h50);
        start(2'd0);
        rd_ready = 1;
        start(2'd1);
        cycle();
        chk("mid_data", rd_data, 32'h51);
        reset = 0;
        cycle();
        reset = 1;
        chk("rst_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pf", phase_full, 4'b0000);
        chk("rst_err", err_status, 3'b000);

        for (int k = 0; k < 3000; k++) begin
            if (k % 150 == 0) load_length = 3'($urandom_range(0, 7));
            error_valid = 1'($urandom_range(0, 1));
            error_phase = 2'($urandom);
            error_sub_address = 32'($urandom_range(0, 7)) |
                                (($urandom_range(0, 3) == 0) ? ($urandom & ~32'h7) : 32'h0);
            error_value = $urandom;
            error_update_first = ($urandom_range(0, 5) == 0);
            error_phase_read = 2'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            clear_errors = ($urandom_range(0, 31) == 0);
            reset = ($urandom_range(0, 299) != 0);
            cycle();
        end
        error_valid = 0; error_update_first = 0; clear_errors = 0; reset = 1;
        drain();
        cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
